ecc_mul_arbiter: RTL and testbench
==================================

# ecc_mul_arbiter

Round-robin arbiter and sequencer that shares one GF(2^163) field-multiplier core among several requesters, for example the ladder core and the coordinate-conversion and inversion units of the ECC multi-core processor. The block takes one operand pair from the granted requester and launches the multiplier. It waits for completion, then returns the product on a shared result bus with a one-hot acknowledge. A watchdog timeout is built in, so a hung multiplier can never deadlock the requesters.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `W`, 163: field element width.
- `TIMEOUT`, 255: maximum number of WAIT cycles before the block aborts; 8-bit counter.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req`  in  NREQ  request, one bit per requester; level, held until the matching ack.
- `op_a`  in  NREQ*W  operand A; requester i uses bits `[i*W +: W]`.
- `op_b`  in  NREQ*W  operand B, same packing as `op_a`.
- `ack`  out  NREQ  one-hot, single-cycle completion pulse.
- `err`  out  1  timeout flag, valid when any `ack` bit is high.
- `res`  out  W  product; valid in the ack cycle and held until the next completion.
- `busy`  out  1  high in every state except IDLE.
- `mul_a`, `mul_b`  out  W  registered operands to the multiplier core.
- `mul_start`  out  1  single-cycle launch pulse to the core.
- `mul_done`  in  1  single-cycle completion from the core.
- `mul_res`  in  W  product from the core, valid while `mul_done` is high.

## Operation
- **Reset.** All outputs clear to 0. State = IDLE. Round-robin pointer `last` = NREQ-1, so requester 0 has first priority. Watchdog counter = 0.
- **IDLE.** If `req` is nonzero:
  - The winner is the first set bit searching upward from `last+1`, wrapping modulo NREQ.
  - At the clock edge, register the winner index into `gidx`, set `last` to the winner, and latch the winner's operands into `mul_a`/`mul_b`.
  - Go to ISSUE.
  - If `req` is zero, stay in IDLE.
- **ISSUE.** `mul_start` = 1 for this cycle only. Clear the watchdog counter. Go to WAIT.
- **WAIT.** The watchdog counter increments every cycle.
  - **Normal completion.** If `mul_done` = 1: capture `mul_res` into `res`, set `err` = 0, and go to RESP.
  - **Timeout.** Otherwise, if the counter reaches TIMEOUT: set `res` = 0, set `err` = 1, and go to RESP.
  - **Simultaneous events.** If `mul_done` and the timeout occur in the same cycle, completion wins and `err` = 0.
- **RESP.**
  - `ack[gidx]` = 1 for one cycle; `err` is valid in the same cycle. Go to IDLE.
  - Early withdrawal: if `req[gidx]` was sampled low during WAIT, the ack pulse is suppressed. `res` is still updated. This is used to drop an abandoned job; the multiplier cannot be aborted.
- **Stray done.** `mul_done` outside WAIT is ignored, and `res` does not change.
- **Requester rule.** The requester must deassert `req` no later than the cycle after its ack, otherwise it is regranted.
  - Its operands must stay stable only until the cycle in which it is granted, because they are latched in IDLE.
- **Fairness.** A requester that is continuously asserted waits at most NREQ-1 other jobs.
- **Reset mid-operation.** Asserting `rst` in ISSUE or WAIT returns the block to IDLE immediately and drops the job without an ack.
  - The core must be reset by the same `rst`.

## Timing
- Request accepted in cycle 0 (IDLE) → `mul_start` in cycle 1 → `mul_done` sampled in cycle d → `ack`/`res` in cycle d+1 → IDLE in cycle d+2.
- Minimum spacing between consecutive `mul_start` pulses is core latency + 3 cycles, where core latency = d−1.
- Timeout path: `ack` with `err` = 1 in cycle TIMEOUT+2.
- `busy` rises in cycle 1 and falls in cycle d+2.
- `req` only affects arbitration in IDLE. Changes in other states are ignored, except the early-withdrawal check in WAIT.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- **Single request.** Stimulus: `req`=0001, `op_a`=`op_b`=163'h2, core model with 10-cycle latency returning 163'h4. Required response:
  - `mul_start` exactly in cycle 1.
  - `ack`=0001, `res`=163'h4, `err`=0 in cycle 12.
  - `busy` low from cycle 13.
- **All four requesting continuously.** Stimulus: `req`=1111 held, each requester dropping its `req` the cycle after its ack. Required response:
  - Grant order 0,1,2,3.
  - Operands on `mul_a` match each granted requester.
  - No requester is granted twice before all four are served.
- **Pointer wrap.** Stimulus: after requester 3 is served, `req`=1001. Required response: requester 0 is granted next, then requester 3.
- **Watchdog timeout.** Stimulus: TIMEOUT=20, core never asserts `mul_done`. Required response:
  - `ack` for the granted requester in cycle 22, with `err`=1 and `res`=0.
  - Next request then proceeds normally.
- **Boundary events.** Stimuli and required responses:
  - `mul_done` exactly on the timeout cycle: `err`=0 and `res`=`mul_res`.
  - Stray `mul_done` while in IDLE: `res` is unchanged.
  - Requester drops `req` during WAIT: no ack pulse, `res` is updated, state returns to IDLE.
- **Asynchronous reset mid-WAIT.** Stimulus: `rst` pulsed in cycle 5 of a 10-cycle job. Required response:
  - All outputs are 0 immediately, without waiting for a clock edge.
  - No ack for the dropped job.
  - After release, requester 0 has first priority again.

Source files
------------

// File: rtl/ecc_mul_arbiter_if.sv
// rtl/ecc_mul_arbiter_if.sv - requester and multiplier-core bus of the shared GF(2^163) multiplier arbiter
// slave is the arbiter side; master is the requesters plus the multiplier core.
interface ecc_mul_arbiter_if #(
  parameter int NREQ = 4,
  parameter int W    = 163
);
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] op_a;
  logic [NREQ*W-1:0] op_b;
  logic [NREQ-1:0]   ack;
  logic              err;
  logic [W-1:0]      res;
  logic              busy;
  logic [W-1:0]      mul_a;
  logic [W-1:0]      mul_b;
  logic              mul_start;
  logic              mul_done;
  logic [W-1:0]      mul_res;

  modport slave (
    input  req, op_a, op_b, mul_done, mul_res,
    output ack, err, res, busy, mul_a, mul_b, mul_start
  );

  modport master (
    output req, op_a, op_b, mul_done, mul_res,
    input  ack, err, res, busy, mul_a, mul_b, mul_start
  );
endinterface

// File: rtl/ecc_mul_arbiter.sv
// rtl/ecc_mul_arbiter.sv - round-robin arbiter/sequencer sharing one GF(2^163) multiplier core
// One job at a time: grant, launch, wait for done or watchdog, answer with a one-hot ack.
module ecc_mul_arbiter #(
  parameter int NREQ    = 4,
  parameter int W       = 163,
  parameter int TIMEOUT = 255
) (
  input logic              clk,
  input logic              rst,
  ecc_mul_arbiter_if.slave bus
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state, state_next;
  logic [IW-1:0]   last, last_next;
  logic [IW-1:0]   gidx, gidx_next;
  logic [7:0]      wdog, wdog_next;
  logic            withdrawn, withdrawn_next;
  logic [NREQ-1:0] ack_q, ack_next;
  logic            err_q, err_next;
  logic [W-1:0]    res_q, res_next;
  logic [W-1:0]    a_q, a_next;
  logic [W-1:0]    b_q, b_next;
  logic            start_q, start_next;
  logic            busy_q, busy_next;
  logic [IW-1:0]   win;
  logic            win_valid;
  logic            keep_ack;

  function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NREQ) s = s - NREQ;
    return IW'(s);
  endfunction

  // Scan from the farthest candidate down so the nearest one after 'last' wins.
  always_comb begin
    win       = '0;
    win_valid = 1'b0;
    for (int k = NREQ; k >= 1; k--) begin
      if (bus.req[wrap_idx(last, k)]) begin
        win       = wrap_idx(last, k);
        win_valid = 1'b1;
      end
    end
  end

  always_comb begin
    state_next     = state;
    last_next      = last;
    gidx_next      = gidx;
    wdog_next      = wdog;
    withdrawn_next = withdrawn;
    ack_next       = '0;
    err_next       = err_q;
    res_next       = res_q;
    a_next         = a_q;
    b_next         = b_q;
    start_next     = 1'b0;
    keep_ack       = !withdrawn && bus.req[gidx];

    case (state)
      IDLE: begin
        if (win_valid) begin
          gidx_next  = win;
          last_next  = win;
          a_next     = bus.op_a[int'(win)*W +: W];
          b_next     = bus.op_b[int'(win)*W +: W];
          start_next = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        wdog_next      = '0;
        withdrawn_next = 1'b0;
        state_next     = WAIT;
      end
      WAIT: begin
        wdog_next = wdog + 8'd1;
        if (!bus.req[gidx]) withdrawn_next = 1'b1;
        // Completion is checked first so a done on the timeout cycle still counts.
        if (bus.mul_done) begin
          res_next       = bus.mul_res;
          err_next       = 1'b0;
          ack_next[gidx] = keep_ack;
          state_next     = RESP;
        end else if (wdog == WD_LAST) begin
          res_next       = '0;
          err_next       = 1'b1;
          ack_next[gidx] = keep_ack;
          state_next     = RESP;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      last      <= IW'(NREQ - 1);
      gidx      <= '0;
      wdog      <= '0;
      withdrawn <= 1'b0;
      ack_q     <= '0;
      err_q     <= 1'b0;
      res_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state     <= state_next;
      last      <= last_next;
      gidx      <= gidx_next;
      wdog      <= wdog_next;
      withdrawn <= withdrawn_next;
      ack_q     <= ack_next;
      err_q     <= err_next;
      res_q     <= res_next;
      a_q       <= a_next;
      b_q       <= b_next;
      start_q   <= start_next;
      busy_q    <= busy_next;
    end
  end

  assign bus.ack       = ack_q;
  assign bus.err       = err_q;
  assign bus.res       = res_q;
  assign bus.busy      = busy_q;
  assign bus.mul_a     = a_q;
  assign bus.mul_b     = b_q;
  assign bus.mul_start = start_q;
endmodule

// File: tb/tb_ecc_mul_arbiter.sv
// tb/tb_ecc_mul_arbiter.sv - directed self-checking bench for ecc_mul_arbiter
// A behavioural core answers each mul_start after core_lat cycles; outputs are sampled on negedges.
module tb_ecc_mul_arbiter;
  localparam int NREQ = 4;
  localparam int W    = 163;
  localparam int TO   = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ecc_mul_arbiter_if #(.NREQ(NREQ), .W(W)) bus();
  ecc_mul_arbiter #(.NREQ(NREQ), .W(W), .TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

  int tests = 0;
  int fails = 0;

  int           core_lat  = 10;
  bit           core_hang = 1'b0;
  bit           stray_req = 1'b0;
  logic [W-1:0] core_val  = '0;
  int           core_cnt  = 0;

  always @(posedge clk) begin
    #1;
    if (rst) begin
      core_cnt     = 0;
      bus.mul_done = 1'b0;
      bus.mul_res  = '0;
    end else begin
      bus.mul_done = 1'b0;
      if (stray_req) begin
        bus.mul_done = 1'b1;
        bus.mul_res  = {W{1'b1}};
      end
      if (core_cnt > 0) begin
        core_cnt = core_cnt - 1;
        if (core_cnt == 0) begin
          bus.mul_done = 1'b1;
          bus.mul_res  = core_val;
        end
      end
      if (bus.mul_start && !core_hang) core_cnt = core_lat;
    end
  end

  task automatic load_ops();
    for (int i = 0; i < NREQ; i++) begin
      bus.op_a[i*W +: W] = W'(32'h100 + i);
      bus.op_b[i*W +: W] = W'(32'h200 + i);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      if (bus.mul_start === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_ack(output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      if (bus.ack !== 4'b0000) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req = '0;
    load_ops();
    repeat (3) @(negedge clk);
    tests++; if (bus.ack !== 4'b0000) begin fails++; $display("FAIL reset_ack: got %b expected 0000", bus.ack); end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    tests++; if (bus.err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b expected 0", bus.err); end
    tests++; if (bus.res !== '0) begin fails++; $display("FAIL reset_res: got %h expected 0", bus.res); end
    tests++; if (bus.mul_start !== 1'b0) begin fails++; $display("FAIL reset_start: got %b expected 0", bus.mul_start); end
    tests++; if (bus.mul_a !== '0) begin fails++; $display("FAIL reset_mul_a: got %h expected 0", bus.mul_a); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    do_reset();
    core_lat  = 10;
    core_hang = 1'b0;
    core_val  = W'(4);
    bus.op_a[0 +: W] = W'(2);
    bus.op_b[0 +: W] = W'(2);
    bus.req = 4'b0001;
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      tests++; if (bus.mul_start !== (c == 1)) begin fails++; $display("FAIL single_start c%0d: got %b expected %b", c, bus.mul_start, (c == 1)); end
      tests++; if (bus.ack !== ((c == 12) ? 4'b0001 : 4'b0000)) begin fails++; $display("FAIL single_ack c%0d: got %b", c, bus.ack); end
      tests++; if (bus.busy !== (c <= 12)) begin fails++; $display("FAIL single_busy c%0d: got %b expected %b", c, bus.busy, (c <= 12)); end
      if (c == 1) begin
        tests++; if (bus.mul_a !== W'(2)) begin fails++; $display("FAIL single_mul_a: got %h expected 2", bus.mul_a); end
      end
      if (c == 12) begin
        tests++; if (bus.res !== W'(4)) begin fails++; $display("FAIL single_res: got %h expected 4", bus.res); end
        tests++; if (bus.err !== 1'b0) begin fails++; $display("FAIL single_err: got %b expected 0", bus.err); end
        bus.req = 4'b0000;
      end
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    logic [W-1:0] exp_a, exp_b;
    do_reset();
    load_ops();
    core_lat = 3;
    core_val = W'(32'h55);
    bus.req  = 4'b1111;
    for (int g = 0; g < NREQ; g++) begin
      exp_a = W'(32'h100 + g);
      exp_b = W'(32'h200 + g);
      wait_start(ok);
      tests++; if (!ok) begin fails++; $display("FAIL rr_start_timeout g%0d: got none expected mul_start", g); end
      tests++; if (bus.mul_a !== exp_a) begin fails++; $display("FAIL rr_mul_a g%0d: got %h expected %h", g, bus.mul_a, exp_a); end
      tests++; if (bus.mul_b !== exp_b) begin fails++; $display("FAIL rr_mul_b g%0d: got %h expected %h", g, bus.mul_b, exp_b); end
      wait_ack(ok);
      tests++; if (bus.ack !== 4'(1 << g)) begin fails++; $display("FAIL rr_ack g%0d: got %b expected %b", g, bus.ack, 4'(1 << g)); end
      bus.req[g] = 1'b0;
    end
  endtask

  task automatic test_wrap();
    bit ok;
    int order [2];
    order[0] = 0;
    order[1] = 3;
    @(negedge clk);
    bus.req = 4'b1001;
    for (int j = 0; j < 2; j++) begin
      wait_ack(ok);
      tests++; if (bus.ack !== 4'(1 << order[j])) begin fails++; $display("FAIL wrap_ack j%0d: got %b expected %b", j, bus.ack, 4'(1 << order[j])); end
      bus.req[order[j]] = 1'b0;
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_timeout();
    bit ok;
    core_hang = 1'b1;
    bus.req   = 4'b0010;
    for (int c = 1; c <= 22; c++) begin
      @(negedge clk);
      tests++; if (bus.ack !== ((c == 22) ? 4'b0010 : 4'b0000)) begin fails++; $display("FAIL to_ack c%0d: got %b", c, bus.ack); end
      if (c == 22) begin
        tests++; if (bus.err !== 1'b1) begin fails++; $display("FAIL to_err: got %b expected 1", bus.err); end
        tests++; if (bus.res !== '0) begin fails++; $display("FAIL to_res: got %h expected 0", bus.res); end
        bus.req = 4'b0000;
      end
    end
    core_hang = 1'b0;
    core_lat  = 4;
    core_val  = W'(32'h99);
    @(negedge clk);
    bus.req = 4'b0100;
    wait_ack(ok);
    tests++; if (bus.ack !== 4'b0100) begin fails++; $display("FAIL to_next_ack: got %b expected 0100", bus.ack); end
    tests++; if (bus.err !== 1'b0) begin fails++; $display("FAIL to_next_err: got %b expected 0", bus.err); end
    tests++; if (bus.res !== W'(32'h99)) begin fails++; $display("FAIL to_next_res: got %h expected 99", bus.res); end
    bus.req = 4'b0000;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_boundary();
    logic [NREQ-1:0] seen;
    core_lat = TO;
    core_val = W'(32'hABC);
    bus.req  = 4'b0001;
    for (int c = 1; c <= 22; c++) begin
      @(negedge clk);
      tests++; if (bus.ack !== ((c == 22) ? 4'b0001 : 4'b0000)) begin fails++; $display("FAIL edge_ack c%0d: got %b", c, bus.ack); end
      if (c == 22) begin
        tests++; if (bus.err !== 1'b0) begin fails++; $display("FAIL edge_err: got %b expected 0", bus.err); end
        tests++; if (bus.res !== W'(32'hABC)) begin fails++; $display("FAIL edge_res: got %h expected abc", bus.res); end
        bus.req = 4'b0000;
      end
    end
    repeat (2) @(negedge clk);
    stray_req = 1'b1;
    @(negedge clk);
    stray_req = 1'b0;
    seen = '0;
    repeat (4) begin
      @(negedge clk);
      seen = seen | bus.ack;
    end
    tests++; if (bus.res !== W'(32'hABC)) begin fails++; $display("FAIL stray_res: got %h expected abc", bus.res); end
    tests++; if (seen !== 4'b0000) begin fails++; $display("FAIL stray_ack: got %b expected 0000", seen); end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL stray_busy: got %b expected 0", bus.busy); end
    core_lat = 5;
    core_val = W'(32'hDEF);
    bus.req  = 4'b0010;
    seen = '0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      seen = seen | bus.ack;
      if (c == 3) bus.req = 4'b0000;
    end
    tests++; if (seen !== 4'b0000) begin fails++; $display("FAIL drop_ack: got %b expected 0000", seen); end
    tests++; if (bus.res !== W'(32'hDEF)) begin fails++; $display("FAIL drop_res: got %h expected def", bus.res); end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL drop_busy: got %b expected 0", bus.busy); end
  endtask

  task automatic test_async_reset();
    bit ok;
    core_lat = 10;
    core_val = W'(32'h123);
    bus.req  = 4'b1001;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL arst_busy: got %b expected 0", bus.busy); end
    tests++; if (bus.res !== '0) begin fails++; $display("FAIL arst_res: got %h expected 0", bus.res); end
    tests++; if (bus.mul_a !== '0) begin fails++; $display("FAIL arst_mul_a: got %h expected 0", bus.mul_a); end
    tests++; if (bus.mul_b !== '0) begin fails++; $display("FAIL arst_mul_b: got %h expected 0", bus.mul_b); end
    tests++; if (bus.ack !== 4'b0000 || bus.err !== 1'b0 || bus.mul_start !== 1'b0) begin fails++; $display("FAIL arst_ctrl: got ack %b err %b start %b expected all 0", bus.ack, bus.err, bus.mul_start); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_start(ok);
    tests++; if (!ok || bus.mul_a !== W'(32'h100)) begin fails++; $display("FAIL arst_first_grant: got %h expected 100", bus.mul_a); end
    wait_ack(ok);
    tests++; if (bus.ack !== 4'b0001) begin fails++; $display("FAIL arst_ack: got %b expected 0001", bus.ack); end
    bus.req = 4'b0000;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    bus.req  = '0;
    bus.op_a = '0;
    bus.op_b = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_timeout();
    test_boundary();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule
